// File: rtl/riscv_single_cycle_pkg.sv
// Shared encodings, control bundle and immediate extender
// for the single-cycle RV32I core.
package riscv_single_cycle_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  localparam logic [1:0] ASRC_REG    = 2'b00;
  localparam logic [1:0] ASRC_IMM    = 2'b01;
  localparam logic [1:0] ASRC_PC_IMM = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef struct packed {
    logic       reg_we;
    logic       mem_we;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src;
    logic [1:0] res_src;
  } ctrl_t;

  function automatic logic [31:0] imm_ext(
    input logic [31:7] ins,
    input logic [2:0]  sel
  );
    logic [31:0] imm;
    case (sel)
      IMM_I: imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S: imm = {{20{ins[31]}}, ins[31:25],
                    ins[11:7]};
      IMM_B: imm = {{19{ins[31]}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};
      IMM_J: imm = {{11{ins[31]}}, ins[31],
                    ins[19:12], ins[20],
                    ins[30:21], 1'b0};
      IMM_U: imm = {ins[31:12], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // sub only exists in R-type; srai/sra share funct7 bit 5
  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_r
  );
    logic [3:0] op;
    case (f3)
      3'b000: op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_single_cycle_if.sv
// Controller-to-datapath bundle: decoded controls out,
// ALU zero flag back.
interface riscv_single_cycle_if;
  import riscv_single_cycle_pkg::*;

  ctrl_t      ctl;
  logic [1:0] pc_src;
  logic       zero;

  modport master (
    output ctl,
    output pc_src,
    input  zero
  );

  modport slave (
    input  ctl,
    input  pc_src,
    output zero
  );

endinterface

// File: rtl/riscv_single_cycle_alu.sv
// 32-bit ALU with zero flag; shifts use b[4:0].
module riscv_single_cycle_alu
  import riscv_single_cycle_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/riscv_single_cycle_ctrl.sv
// Combinational main decoder and branch resolution.
// pc_src is kept apart from ctl so zero never loops back.
module riscv_single_cycle_ctrl
  import riscv_single_cycle_pkg::*;
(
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  riscv_single_cycle_if.master bus
);

  ctrl_t      c;
  logic [1:0] nxt;
  logic       take;

  assign take = (funct3 == 3'b000) ?  bus.zero :
                (funct3 == 3'b001) ? !bus.zero :
                1'b0;

  always_comb begin
    c = '0;
    unique case (1'b1)
      opcode == OP_R: begin
        c.reg_we   = 1'b1;
        c.alu_ctrl = alu_dec(funct3, funct7b5, 1'b1);
      end
      opcode == OP_IMM: begin
        c.reg_we   = 1'b1;
        c.imm_src  = IMM_I;
        c.alu_src  = ASRC_IMM;
        c.alu_ctrl = alu_dec(funct3, funct7b5, 1'b0);
      end
      opcode == OP_LOAD: begin
        c.reg_we   = 1'b1;
        c.imm_src  = IMM_I;
        c.alu_src  = ASRC_IMM;
        c.alu_ctrl = ALU_ADD;
        c.res_src  = RES_MEM;
      end
      opcode == OP_STORE: begin
        c.mem_we   = 1'b1;
        c.imm_src  = IMM_S;
        c.alu_src  = ASRC_IMM;
        c.alu_ctrl = ALU_ADD;
      end
      opcode == OP_BRANCH: begin
        c.imm_src  = IMM_B;
        c.alu_ctrl = ALU_SUB;
      end
      opcode == OP_JAL: begin
        c.reg_we   = 1'b1;
        c.imm_src  = IMM_J;
        c.res_src  = RES_PC4;
      end
      opcode == OP_JALR: begin
        c.reg_we   = 1'b1;
        c.imm_src  = IMM_I;
        c.alu_src  = ASRC_IMM;
        c.alu_ctrl = ALU_ADD;
        c.res_src  = RES_PC4;
      end
      opcode == OP_LUI: begin
        c.reg_we   = 1'b1;
        c.imm_src  = IMM_U;
        c.res_src  = RES_IMM;
      end
      opcode == OP_AUIPC: begin
        c.reg_we   = 1'b1;
        c.imm_src  = IMM_U;
        c.alu_src  = ASRC_PC_IMM;
        c.alu_ctrl = ALU_ADD;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = PC_PLUS4;
    unique case (1'b1)
      opcode == OP_JAL:    nxt = PC_TARGET;
      opcode == OP_JALR:   nxt = PC_ALU;
      opcode == OP_BRANCH: nxt = take ? PC_TARGET
                                      : PC_PLUS4;
      default: ;
    endcase
  end

  assign bus.ctl    = c;
  assign bus.pc_src = nxt;

endmodule

// File: rtl/riscv_single_cycle_dp.sv
// Datapath: pc, register file, immediates, ALU and
// write-back / next-pc muxes.
module riscv_single_cycle_dp
  import riscv_single_cycle_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:7]         instr,
  input  logic [31:0]         mem_rd_data,
  riscv_single_cycle_if.slave bus,
  output logic [31:0]         pc,
  output logic [31:0]         alu_out,
  output logic [31:0]         mem_wd_data
);

  // power-up value so pc reads 0 before the first edge
  logic [31:0] pc_r = '0;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] pc4;
  logic [31:0] pc_tgt;
  logic [31:0] next_pc;
  logic [31:0] result;
  logic        zero;

  assign imm    = imm_ext(instr, bus.ctl.imm_src);
  assign pc4    = pc_r + 32'd4;
  assign pc_tgt = pc_r + imm;
  assign src_a  = bus.ctl.alu_src[1] ? pc_r : rs1;
  assign src_b  = bus.ctl.alu_src[0] ? imm : rs2;

  riscv_single_cycle_alu alu (
    .a    (src_a),
    .b    (src_b),
    .op   (bus.ctl.alu_ctrl),
    .y    (alu_out),
    .zero (zero)
  );

  always_comb begin
    result = alu_out;
    case (bus.ctl.res_src)
      RES_MEM: result = mem_rd_data;
      RES_PC4: result = pc4;
      RES_IMM: result = imm;
      default: result = alu_out;
    endcase
  end

  always_comb begin
    next_pc = pc4;
    case (bus.pc_src)
      PC_TARGET: next_pc = pc_tgt;
      PC_ALU:    next_pc = {alu_out[31:1], 1'b0};
      default:   next_pc = pc4;
    endcase
  end

  riscv_single_cycle_rf rf (
    .clk (clk),
    .we  (bus.ctl.reg_we & rst),
    .ra1 (instr[19:15]),
    .ra2 (instr[24:20]),
    .wa  (instr[11:7]),
    .wd  (result),
    .rd1 (rs1),
    .rd2 (rs2)
  );

  always_ff @(posedge clk) begin
    if (!rst) pc_r <= '0;
    else      pc_r <= next_pc;
  end

  assign bus.zero    = zero;
  assign pc          = pc_r;
  assign mem_wd_data = rs2;

endmodule

// File: rtl/riscv_single_cycle_mem.sv
// 64-word memory: combinational read, synchronous write.
// Used for both instruction and data storage.
module riscv_single_cycle_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  logic [31:0] _mem [64];

  always_ff @(posedge clk) begin
    if (we) _mem[addr] <= wd;
  end

  assign rd = _mem[addr];

endmodule

// File: rtl/riscv_single_cycle_rf.sv
// 32x32 register file: two async reads, one sync write.
// x0 is never stored and always reads as zero.
module riscv_single_cycle_rf (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] _reg [32];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) _reg[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : _reg[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : _reg[ra2];

endmodule

// File: rtl/riscv_single_cycle_top.sv
// Single-cycle RV32I core: controller, datapath and the
// two 64-word memories, with controls exported.
module riscv_single_cycle_top
  import riscv_single_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        reg_we,
  output logic        mem_we,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  alu_src,
  output logic [1:0]  res_src,
  output logic [1:0]  pc_src,
  output logic [31:0] instr,
  output logic [31:0] alu_out,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_wd_data,
  output logic [31:0] pc
);

  riscv_single_cycle_if cif ();

  riscv_single_cycle_ctrl ctrl (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7b5 (instr[30]),
    .bus      (cif)
  );

  riscv_single_cycle_dp dp (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr[31:7]),
    .mem_rd_data (mem_rd_data),
    .bus         (cif),
    .pc          (pc),
    .alu_out     (alu_out),
    .mem_wd_data (mem_wd_data)
  );

  riscv_single_cycle_mem instr_mem (
    .clk  (clk),
    .we   (1'b0),
    .addr (pc[7:2]),
    .wd   (32'h0),
    .rd   (instr)
  );

  // stores in flight during reset are dropped
  riscv_single_cycle_mem data_mem (
    .clk  (clk),
    .we   (cif.ctl.mem_we & rst),
    .addr (alu_out[7:2]),
    .wd   (mem_wd_data),
    .rd   (mem_rd_data)
  );

  assign reg_we   = cif.ctl.reg_we;
  assign mem_we   = cif.ctl.mem_we;
  assign imm_src  = cif.ctl.imm_src;
  assign alu_ctrl = cif.ctl.alu_ctrl;
  assign alu_src  = cif.ctl.alu_src;
  assign res_src  = cif.ctl.res_src;
  assign pc_src   = cif.pc_src;

endmodule

// File: tb/tb_riscv_single_cycle_top.sv
// Directed plus randomized bench for riscv_single_cycle_top
// against an instruction-level reference model.
module tb_riscv_single_cycle_top;

  logic        clk;
  logic        rst;
  logic        reg_we;
  logic        mem_we;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src;
  logic [1:0]  res_src;
  logic [1:0]  pc_src;
  logic [31:0] instr;
  logic [31:0] alu_out;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wd_data;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mpc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // op index: add sub and or xor sll srl sra slt sltu
  logic [2:0] rf3 [10] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4,
                           3'd1, 3'd5, 3'd5, 3'd2, 3'd3};
  logic [6:0] rf7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00,
                           7'h00, 7'h00, 7'h00, 7'h20,
                           7'h00, 7'h00};

  riscv_single_cycle_top dut (
    .clk         (clk),
    .rst         (rst),
    .reg_we      (reg_we),
    .mem_we      (mem_we),
    .imm_src     (imm_src),
    .alu_ctrl    (alu_ctrl),
    .alu_src     (alu_src),
    .res_src     (res_src),
    .pc_src      (pc_src),
    .instr       (instr),
    .alu_out     (alu_out),
    .mem_rd_data (mem_rd_data),
    .mem_wd_data (mem_wd_data),
    .pc          (pc)
  );

  riscv_single_cycle_if mon ();

  assign mon.ctl    = {reg_we, mem_we, imm_src, alu_ctrl,
                       alu_src, res_src};
  assign mon.pc_src = pc_src;
  assign mon.zero   = dut.cif.zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, 5'd0, f3,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'h6f};
  endfunction

  function automatic logic [31:0] ref_alu(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b);
    int sa;
    int sb;
    int unsigned s;
    sa = a;
    sb = b;
    s  = 32'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: return a[31] ? ~((~a) >> s) : (a >> s);
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setr(input logic [4:0] r,
                      input logic [31:0] v);
    dut.dp.rf._reg[r] = v;
  endtask

  function automatic logic [31:0] getr(input logic [4:0] r);
    return dut.dp.rf._reg[r];
  endfunction

  task automatic load(input logic [31:0] w);
    dut.instr_mem._mem[mpc[7:2]] = w;
    #1;
  endtask

  task automatic tick(input logic [31:0] nxt);
    @(posedge clk);
    #1;
    mpc = nxt;
    chk("pc", pc, mpc);
  endtask

  task automatic exe(input logic [31:0] w);
    load(w);
    tick(mpc + 32'd4);
  endtask

  initial begin
    rst = 1'b0;
    mpc = '0;
    for (int i = 0; i < 32; i++) setr(5'(i), 32'h0);
    for (int i = 0; i < 64; i++) begin
      dut.instr_mem._mem[i] = NOP;
      dut.data_mem._mem[i]  = 32'h0;
    end
    dut.instr_mem._mem[0] = 32'h0ffff097;
    #1;
    chk("pc_t0", pc, 32'h0);

    @(posedge clk);
    #1;
    chk("pc_rst", pc, 32'h0);
    chk("x1_rst_sup", getr(5'd1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("instr_auipc", instr, 32'h0ffff097);
    chk("imm_src", 32'(mon.ctl.imm_src), 32'd4);
    chk("alu_src", 32'(mon.ctl.alu_src), 32'd3);
    chk("res_src", 32'(mon.ctl.res_src), 32'd0);
    chk("reg_we", 32'(mon.ctl.reg_we), 32'd1);
    tick(32'd4);
    chk("auipc_x1", getr(5'd1), 32'h0ffff000);

    setr(5'd1, 32'd12);
    setr(5'd2, 32'd5);
    exe(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    chk("add", getr(5'd3), 32'd17);
    exe(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
    chk("sub", getr(5'd3), 32'd7);
    setr(5'd1, 32'h8000_0000);
    setr(5'd2, 32'd4);
    exe(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3));
    chk("sra", getr(5'd3), 32'hf800_0000);
    setr(5'd1, 32'hffff_ffff);
    setr(5'd2, 32'd1);
    exe(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3));
    chk("slt", getr(5'd3), 32'd1);

    setr(5'd1, 32'd12);
    load(enc_s(12'd8, 5'd1, 5'd0));
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_wd", mem_wd_data, 32'd12);
    tick(mpc + 32'd4);
    chk("sw_mem", dut.data_mem._mem[2], 32'd12);
    load(enc_i(12'd8, 5'd0, 3'd2, 5'd4, 7'h03));
    chk("lw_rd_data", mem_rd_data, 32'd12);
    tick(mpc + 32'd4);
    chk("lw_x4", getr(5'd4), 32'd12);

    load({20'h12345, 5'd8, 7'h37});
    chk("lui_res_src", 32'(mon.ctl.res_src), 32'd3);
    tick(mpc + 32'd4);
    chk("lui_x8", getr(5'd8), 32'h1234_5000);

    setr(5'd1, 32'h55);
    load(enc_s(12'd12, 5'd1, 5'd0));
    rst = 1'b0;
    tick(32'd0);
    chk("rst_sw_sup", dut.data_mem._mem[3], 32'h0);
    chk("rst_keep_x4", getr(5'd4), 32'd12);
    chk("rst_keep_x8", getr(5'd8), 32'h1234_5000);
    setr(5'd7, 32'h77);
    load(enc_i(12'd99, 5'd0, 3'd0, 5'd7, 7'h13));
    tick(32'd0);
    chk("rst_addi_sup", getr(5'd7), 32'h77);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) exe(NOP);
    load(enc_b(13'd8, 3'd0));
    chk("beq_zero", 32'(mon.zero), 32'd1);
    chk("beq_pc_src", 32'(mon.pc_src), 32'd1);
    tick(32'h18);

    rst = 1'b0;
    load(NOP);
    tick(32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exe(NOP);
    load(enc_b(13'd8, 3'd1));
    chk("bne_pc_src", 32'(mon.pc_src), 32'd0);
    tick(32'h14);

    for (int i = 0; i < 3; i++) exe(NOP);
    load(enc_j(21'd16, 5'd5));
    tick(32'h30);
    chk("jal_x5", getr(5'd5), 32'h24);

    setr(5'd1, 32'h40);
    load(enc_i(12'd3, 5'd1, 3'd0, 5'd6, 7'h67));
    tick(32'h42);
    chk("jalr_x6", getr(5'd6), 32'h34);

    exe(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));
    chk("x0_zero", getr(5'd0), 32'h0);

    // random ALU traffic, long enough to wrap pc[7:2]
    for (int k = 0; k < 60; k++) begin
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  rd;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ex;
      logic [11:0] imm;
      logic [4:0]  sh;
      r1 = 5'($urandom_range(1, 31));
      r2 = 5'($urandom_range(1, 31));
      rd = 5'($urandom_range(1, 31));
      op = 4'($urandom_range(0, 9));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      setr(r1, a);
      if (r2 == r1) b = a;
      else setr(r2, b);
      if ($urandom_range(0, 1) == 1) begin
        ex = ref_alu(op, a, b);
        exe(enc_r(rf7[op], r2, r1, rf3[op], rd));
        chk("rnd_r", getr(rd), ex);
      end else begin
        if (op == 4'd1) op = 4'd0;
        sh  = 5'($urandom);
        imm = 12'($urandom);
        if (op == 4'd5 || op == 4'd6)
          imm = {7'h00, sh};
        if (op == 4'd7)
          imm = {7'h20, sh};
        ex = ref_alu(op, a, {{20{imm[11]}}, imm});
        exe(enc_i(imm, r1, rf3[op], rd, 7'h13));
        chk("rnd_i", getr(rd), ex);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
